mmio_store_sink: RTL and testbench
==================================

# mmio_store_sink

Memory-mapped responder on the core's data-store port. It watches every store the processor issues (write enable, byte address, store data) and captures stores that hit its address window into a FIFO. A downstream consumer, such as a UART transmitter or debug host, drains the FIFO through a valid/ready handshake. A second register in the window provides overflow-clear and flush control, so firmware can stream words out of the single-cycle core without stalling it.

## Interface
Parameters:
- DEPTH, 8: FIFO entries. Power of 2, at least 2.
- BASE_ADDR, 32'h0000_0400: byte base address of the window. Aligned to 16 bytes.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- areset, input, 1: reset, asynchronous and active-high.
- WE, input, 1: core store enable, valid for the whole cycle.
- addr, input, 32: core byte address (ALU result).
- data_in, input, 32: core store data.
- m_valid, output, 1: the head entry is available.
- m_ready, input, 1: the consumer accepts the head entry.
- m_data, output, 32: head entry data.
- count, output, $clog2(DEPTH)+1: current occupancy.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- overflow, output, 1: sticky flag; a push was dropped.

## Operation
- Hit: WE && addr[31:4] == BASE_ADDR[31:4]. Offset is addr[3:2]. addr[1:0] is ignored.
- Offset 0 (DATA): push data_in.
- Offset 1 (CTRL):
  - data_in[0] = 1 clears overflow.
  - data_in[1] = 1 flushes the FIFO.
  - Both bits may be set together.
- Offsets 2 and 3 are reserved. Writes to them have no effect.
- Non-hit stores and cycles with WE low have no effect.
- Push: when not full, write mem[wr_ptr] and increment wr_ptr.
- Push when full:
  - Without a pop in the same cycle: data is dropped and overflow sets to 1 on the next edge.
  - With a pop in the same cycle (m_valid && m_ready): the push is accepted and count stays at DEPTH.
- Pop: on m_valid && m_ready, increment rd_ptr.
- Simultaneous push and pop on a non-full FIFO: both occur and count is unchanged.
- Pointers have log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately (or derived from pointers with an extra wrap bit) so that full and empty are unambiguous.
- Flush: rd_ptr, wr_ptr and count go to 0 on the next edge. A pop in the same cycle is discarded. Stored data is not cleared.
- overflow is only set by a dropped DATA push and only cleared by a CTRL bit0 write. Both cannot happen in the same cycle, because the core issues one store per cycle.
- m_valid = !empty. m_data = mem[rd_ptr], combinational from the registered array and pointer.
- Protocol rule: m_data must stay stable while m_valid && !m_ready.
- The block never stalls the core. There is no back-pressure on WE.

## Timing
- Reset (async assert, sync effect until released):
  - rd_ptr = wr_ptr = 0, count = 0, overflow = 0.
  - The memory array is cleared to 0, so m_data = 0, m_valid = 0, empty = 1, full = 0.
- Latency from a store to visibility: DATA store in cycle N gives m_valid = 1 and m_data = the stored word in cycle N+1.
- Pop: entry accepted at edge N. The next entry (or m_valid = 0) appears in cycle N+1.
- Status outputs (count, full, empty, overflow) are registered or derived from registers. They reflect all events up to the previous edge.
- Reset asserted mid-stream: all entries are lost immediately. m_valid drops asynchronously with reset.

## Structure
- Package mmio_sink_pkg contains:
  - offset constants OFF_DATA = 2'd0 and OFF_CTRL = 2'd1;
  - CTRL bit indices CTRL_CLR_OVF = 0 and CTRL_FLUSH = 1;
  - the default BASE_ADDR.
- Sub-module sync_fifo, with parameters WIDTH and DEPTH:
  - inputs push, pop, flush;
  - outputs full, empty, count, head.
- mmio_store_sink contains:
  - address decode;
  - overflow logic;
  - an instance of sync_fifo.

## Test plan
- Reset, then three DATA stores to 0x400 with data 0x11, 0x22, 0x33, with m_ready = 0. Required: count = 3; m_data = 0x11 from the cycle after the first store onward.
- Fill DEPTH = 8, then store 0xDEAD with m_ready = 0. Required: 0xDEAD is dropped; overflow = 1 the next cycle; count stays 8. Then store 1 to 0x404. Required: overflow = 0.
- Full FIFO: in the same cycle, m_ready = 1 and DATA store 0x99. Required: count stays 8; 0x99 is read out last after the 7 older entries.
- Stores to 0x408 and 0x500, and a cycle with WE = 0 and addr = 0x400. Required: count unchanged; no overflow.
- Continuous pushes and pops across more than 2*DEPTH words with random m_ready. Required: output order equals input order through pointer wrap.
- With 4 entries queued, store 2 to 0x404 while m_ready = 1. Required: count = 0 and empty = 1 next cycle. Also assert areset mid-stream. Required: m_valid = 0 and overflow = 0 immediately.

Source files
------------

// File: rtl/mmio_sink_pkg.sv
// mmio_sink_pkg: shared constants for the memory-mapped store sink.
//   OFF_DATA / OFF_CTRL  - word offsets (addr[3:2]) inside the 16-byte window
//   CTRL_CLR_OVF / CTRL_FLUSH - bit positions in a CTRL store's data word
//   DEFAULT_BASE_ADDR    - window base used when the top is not overridden
package mmio_sink_pkg;

    localparam logic [1:0]  OFF_DATA          = 2'd0;
    localparam logic [1:0]  OFF_CTRL          = 2'd1;

    localparam int          CTRL_CLR_OVF      = 0;
    localparam int          CTRL_FLUSH        = 1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0400;

endpackage

// File: rtl/mmio_store_sink_fifo.sv
// sync_fifo: single-clock FIFO with explicit occupancy counter.
//   clk, areset       - clock, asynchronous active-high reset
//   push, wdata       - write request and its data (dropped if full and no pop)
//   pop               - read request (ignored while empty)
//   flush             - return pointers and count to zero; beats push/pop
//   full, empty       - occupancy flags
//   count             - number of stored entries, 0..DEPTH
//   head              - entry at the read pointer (combinational read)
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic do_pop;
    logic do_push;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, so the slot being freed is reused immediately.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_pop)
                rd_ptr_next = rd_ptr_reg + 1'b1;
            if (do_push)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (do_push && !do_pop)
                count_next = count_reg + 1'b1;
            else if (do_pop && !do_push)
                count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is cleared on reset so the head reads zero afterwards; a flush
    // only moves pointers and leaves old words in place.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or posedge areset) begin
                if (areset)
                    mem_reg[gi] <= '0;
                else if (do_push && (wr_ptr_reg == PTR_W'(gi)))
                    mem_reg[gi] <= wdata;
            end
        end
    endgenerate

endmodule

// File: rtl/mmio_store_sink.sv
// mmio_store_sink: captures core stores that hit a 16-byte window into a
// FIFO drained by a valid/ready consumer. Never stalls the core.
//   clk, areset        - clock, asynchronous active-high reset
//   WE, addr, data_in  - core store port (one store per cycle)
//   m_valid, m_ready, m_data - consumer handshake on the FIFO head
//   count, full, empty - FIFO occupancy
//   overflow           - sticky: a DATA push was dropped; cleared via CTRL bit0
module mmio_store_sink
    import mmio_sink_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     WE,
    input  logic [31:0]              addr,
    input  logic [31:0]              data_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    logic       hit;
    logic [1:0] offset;
    logic       data_wr;
    logic       ctrl_wr;
    logic       pop;
    logic       flush;
    logic       clr_ovf;
    logic       drop;
    logic       overflow_reg, overflow_next;
    logic       unused_addr_lsbs;

    // Byte lane within the word is irrelevant: stores are treated as words.
    assign unused_addr_lsbs = &{1'b0, addr[1:0]};

    assign hit     = WE && (addr[31:4] == BASE_ADDR[31:4]);
    assign offset  = addr[3:2];
    assign data_wr = hit && (offset == OFF_DATA);
    assign ctrl_wr = hit && (offset == OFF_CTRL);
    assign flush   = ctrl_wr && data_in[CTRL_FLUSH];
    assign clr_ovf = ctrl_wr && data_in[CTRL_CLR_OVF];

    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;

    // Dropped only when nothing leaves this cycle to make room.
    assign drop = data_wr && full && !pop;

    always_comb begin
        overflow_next = overflow_reg;
        if (clr_ovf)
            overflow_next = 1'b0;
        else if (drop)
            overflow_next = 1'b1;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            overflow_reg <= 1'b0;
        else
            overflow_reg <= overflow_next;
    end

    assign overflow = overflow_reg;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .areset (areset),
        .push   (data_wr),
        .wdata  (data_in),
        .pop    (pop),
        .flush  (flush),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .head   (m_data)
    );

endmodule

// File: tb/tb_mmio_store_sink.sv
module tb_mmio_store_sink;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mmio_store_sink #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0000_0400)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .WE       (WE),
        .addr     (addr),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    // One core store (or idle cycle if we_v=0) with the given m_ready.
    task automatic cycle(input logic we_v, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy);
        @(negedge clk);
        WE = we_v; addr = a; data_in = d; m_ready = rdy;
        @(posedge clk);
        #1;
        WE = 1'b0; m_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        #2;
        areset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || m_valid !== 1'b0 ||
            m_data !== 32'h0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b m_valid=%b m_data=%h ovf=%b want 0 1 0 0 0 0",
                     count, empty, full, m_valid, m_data, overflow);
        end
        $display("[TB] reset: count=%0d empty=%b", count, empty);
    endtask

    task automatic test_basic_push();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h400, vals[i], 1'b0);
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== 32'h11 || count !== 4'(i + 1)) begin
                tests_failed++;
                $display("FAIL basic_push[%0d]: m_valid=%b m_data=%h count=%0d want 1 00000011 %0d",
                         i, m_valid, m_data, count, i + 1);
            end
            $display("[TB] push %h: count=%0d head=%h", vals[i], count, m_data);
        end
    endtask

    // Pop expected words one per cycle, checking the head before acceptance.
    task automatic drain_expect(input logic [31:0] exp_q [$], input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            m_ready = 1'b1;
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s[%0d]: m_valid=%b m_data=%h want 1 %h", name, i, m_valid, m_data, exp_q[i]);
            end
            $display("[TB] %s pop %0d: data=%h", name, i, m_data);
            @(posedge clk);
            #1;
            m_ready = 1'b0;
        end
        tests_run++;
        if (empty !== 1'b1 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_empty: empty=%b m_valid=%b want 1 0", name, empty, m_valid);
        end
    endtask

    task automatic test_overflow_and_full_pop();
        logic [31:0] exp_q [$];
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h400 + 32'(i % 4 == 0 ? 0 : 0), 32'(i + 1) * 32'h101, 1'b0);
        tests_run++;
        if (full !== 1'b1 || count !== 4'd8) begin
            tests_failed++;
            $display("FAIL fill: full=%b count=%0d want 1 8", full, count);
        end
        cycle(1'b1, 32'h400, 32'hDEAD, 1'b0);
        tests_run++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            tests_failed++;
            $display("FAIL drop: overflow=%b count=%0d want 1 8", overflow, count);
        end
        $display("[TB] store DEAD on full: overflow=%b count=%0d", overflow, count);
        cycle(1'b1, 32'h404, 32'h1, 1'b0);
        tests_run++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            tests_failed++;
            $display("FAIL clr_ovf: overflow=%b count=%0d want 0 8", overflow, count);
        end
        $display("[TB] ctrl clear: overflow=%b", overflow);
        // Push and pop together on a full FIFO.
        cycle(1'b1, 32'h400, 32'h99, 1'b1);
        tests_run++;
        if (count !== 4'd8 || overflow !== 1'b0 || m_data !== 32'h202) begin
            tests_failed++;
            $display("FAIL full_push_pop: count=%0d overflow=%b head=%h want 8 0 00000202",
                     count, overflow, m_data);
        end
        $display("[TB] push 99 + pop on full: count=%0d head=%h", count, m_data);
        for (int i = 2; i <= DEPTH; i++) exp_q.push_back(32'(i) * 32'h101);
        exp_q.push_back(32'h99);
        drain_expect(exp_q, "full_drain");
    endtask

    task automatic test_ignored();
        cycle(1'b1, 32'h400, 32'h5, 1'b0);
        cycle(1'b1, 32'h408, 32'hAAAA, 1'b0);
        cycle(1'b1, 32'h40C, 32'h3, 1'b0);
        cycle(1'b1, 32'h500, 32'hBBBB, 1'b0);
        cycle(1'b0, 32'h400, 32'hCCCC, 1'b0);
        cycle(1'b0, 32'h404, 32'h3, 1'b0);
        tests_run++;
        if (count !== 4'd1 || overflow !== 1'b0 || m_data !== 32'h5) begin
            tests_failed++;
            $display("FAIL ignored: count=%0d overflow=%b head=%h want 1 0 00000005", count, overflow, m_data);
        end
        $display("[TB] ignored stores: count=%0d head=%h", count, m_data);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_stream();
        logic [31:0] q [$];
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        logic rdy, wr, pop_now;
        while ((pushed < 3 * DEPTH || q.size() != 0) && cyc < 400) begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            pop_now = rdy && (q.size() != 0);
            wr = (pushed < 3 * DEPTH) && ($urandom_range(0, 3) != 0) && (q.size() < DEPTH || pop_now);
            tests_run++;
            if (m_valid !== (q.size() != 0) || (q.size() != 0 && m_data !== q[0])) begin
                tests_failed++;
                $display("FAIL stream[%0d]: m_valid=%b m_data=%h want %b %h", cyc, m_valid, m_data,
                         q.size() != 0, (q.size() != 0) ? q[0] : 32'h0);
            end
            WE = wr; addr = 32'h400; data_in = 32'hA500 + 32'(pushed); m_ready = rdy;
            @(posedge clk);
            #1;
            if (pop_now) begin
                $display("[TB] stream pop %0d: data=%h", popped, q[0]);
                void'(q.pop_front());
                popped++;
            end
            if (wr) begin
                q.push_back(32'hA500 + 32'(pushed));
                pushed++;
            end
            WE = 1'b0; m_ready = 1'b0;
            cyc++;
        end
        tests_run++;
        if (popped != 3 * DEPTH || overflow !== 1'b0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_done: popped=%0d overflow=%b empty=%b want %0d 0 1",
                     popped, overflow, empty, 3 * DEPTH);
        end
    endtask

    task automatic test_flush_and_async_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h400, 32'h70 + 32'(i), 1'b0);
        cycle(1'b1, 32'h404, 32'h2, 1'b1);
        tests_run++;
        if (count !== 4'd0 || empty !== 1'b1 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush: count=%0d empty=%b m_valid=%b want 0 1 0", count, empty, m_valid);
        end
        $display("[TB] flush: count=%0d empty=%b", count, empty);
        // After flush, new data starts from slot 0 again.
        cycle(1'b1, 32'h400, 32'h1234, 1'b0);
        tests_run++;
        if (count !== 4'd1 || m_data !== 32'h1234) begin
            tests_failed++;
            $display("FAIL post_flush: count=%0d m_data=%h want 1 00001234", count, m_data);
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h400, 32'hE0 + 32'(i), 1'b0);
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_ovf: overflow=%b want 1", overflow);
        end
        @(negedge clk);
        #2;
        areset = 1'b1;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || overflow !== 1'b0 || count !== 4'd0 || m_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: m_valid=%b overflow=%b count=%0d m_data=%h want 0 0 0 0",
                     m_valid, overflow, count, m_data);
        end
        $display("[TB] async reset: m_valid=%b overflow=%b", m_valid, overflow);
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_overflow_and_full_pop();
        test_ignored();
        test_stream();
        test_flush_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
